// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART: register map, STATUS layout,
// the common four-state serial FSM encoding and bit-timing constants.
package uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int unsigned ST_RX_AVAIL   = 0;
  localparam int unsigned ST_RX_FULL    = 1;
  localparam int unsigned ST_TX_FULL    = 2;
  localparam int unsigned ST_TX_EMPTY   = 3;
  localparam int unsigned ST_TX_BUSY    = 4;
  localparam int unsigned ST_RX_OVERRUN = 5;
  localparam int unsigned ST_FRAME_ERR  = 6;
  localparam int unsigned ST_TX_OVF     = 7;

  localparam int unsigned TICKS_PER_BIT = 16;
  localparam int unsigned TCNT_W        = $clog2(TICKS_PER_BIT);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TICKS_PER_BIT - 1);
  localparam logic [TCNT_W-1:0] TCNT_MID  = TCNT_W'(TICKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;

  // STATUS register image, bit 7 down to bit 0
  typedef struct packed {
    logic tx_ovf;
    logic frame_err;
    logic rx_overrun;
    logic tx_busy;
    logic tx_empty;
    logic tx_full;
    logic rx_full;
    logic rx_avail;
  } status_t;

endpackage

// File: rtl/uart_mmio_fifo.sv
// Synchronous FIFO with extra-bit pointers; a push is visible at head the next cycle.
// Push while full succeeds only if a pop happens on the same edge.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_c_o,
  output logic             full_c_o,
  output logic             empty_c_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign empty_c_o = (wr_ptr_q == rd_ptr_q);
  assign full_c_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop    = pop_i && !empty_c_o;
  assign do_push   = push_i && (!full_c_o || do_pop);
  assign head_c_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/uart_mmio.sv
// Full-duplex UART on the CPU bus: programmable 16x tick generator, TX/RX FIFOs,
// sticky error flags and a registered interrupt request.
module uart_mmio #(
  parameter int unsigned WORD_SIZE   = 16,
  parameter int unsigned TX_DEPTH    = 8,
  parameter int unsigned RX_DEPTH    = 8,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned DEFAULT_DIV = 26
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 sel_i,
  input  logic [1:0]           addr_i,
  input  logic                 we_i,
  input  logic                 re_i,
  input  logic [WORD_SIZE-1:0] wdata_i,
  output logic [WORD_SIZE-1:0] rdata_o,
  input  logic                 rx_i,
  output logic                 tx_o,
  output logic                 irq_o
);
  import uart_pkg::*;

  logic wr_en, rd_en, tick;
  logic [2:0] sts_clr;
  status_t status;

  logic [DIV_W-1:0] div_q, div_d, tick_cnt_q, tick_cnt_d;
  logic [1:0] ctrl_q, ctrl_d;
  logic [WORD_SIZE-1:0] rdata_q, rdata_d;
  logic rx_ovr_q, rx_ovr_d, ferr_q, ferr_d, tx_ovf_q, tx_ovf_d, irq_q, irq_d;

  logic tx_push, tx_pop, tx_full, tx_empty;
  logic rx_push, rx_pop, rx_full, rx_empty, ferr_set;
  logic [7:0] tx_head, rx_head;

  uart_state_e tx_state_q, tx_state_d, rx_state_q, rx_state_d;
  logic [TCNT_W-1:0] tx_tcnt_q, tx_tcnt_d, rx_tcnt_q, rx_tcnt_d;
  logic [2:0] tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [7:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
  logic tx_q, tx_d, rx_s1_q, rx_s2_q, rx_wait_q, rx_wait_d;

  assign wr_en   = sel_i & we_i;
  assign rd_en   = sel_i & re_i;
  assign tx_push = wr_en && (addr_i == REG_DATA);
  assign rx_pop  = rd_en && (addr_i == REG_DATA);
  assign sts_clr = (wr_en && (addr_i == REG_STATUS)) ? wdata_i[ST_TX_OVF:ST_RX_OVERRUN] : 3'b000;
  assign tick    = (tick_cnt_q == div_q);

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk_i(clk_i), .rst_ni(rst_ni), .push_i(tx_push), .pop_i(tx_pop), .data_i(wdata_i[7:0]),
    .head_c_o(tx_head), .full_c_o(tx_full), .empty_c_o(tx_empty)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk_i(clk_i), .rst_ni(rst_ni), .push_i(rx_push), .pop_i(rx_pop), .data_i(rx_sh_q),
    .head_c_o(rx_head), .full_c_o(rx_full), .empty_c_o(rx_empty)
  );

  always_comb begin
    status            = '0;
    status.rx_avail   = !rx_empty;
    status.rx_full    = rx_full;
    status.tx_full    = tx_full;
    status.tx_empty   = tx_empty;
    status.tx_busy    = (tx_state_q != IDLE);
    status.rx_overrun = rx_ovr_q;
    status.frame_err  = ferr_q;
    status.tx_ovf     = tx_ovf_q;
  end

  // Register file, read path, sticky flags (hardware set wins over clear) and irq
  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + DIV_W'(1);
    div_d      = div_q;
    ctrl_d     = ctrl_q;
    rdata_d    = rdata_q;
    if (wr_en && (addr_i == REG_DIV)) begin
      div_d      = DIV_W'(wdata_i);
      tick_cnt_d = '0;
    end
    if (wr_en && (addr_i == REG_CTRL)) ctrl_d = wdata_i[1:0];
    if (rd_en) begin
      case (addr_i)
        REG_DATA:   rdata_d = rx_empty ? '0 : WORD_SIZE'(rx_head);
        REG_STATUS: rdata_d = WORD_SIZE'(status);
        REG_DIV:    rdata_d = WORD_SIZE'(div_q);
        default:    rdata_d = WORD_SIZE'(ctrl_q);
      endcase
    end
    rx_ovr_d = (rx_ovr_q & ~sts_clr[0]) | (rx_push && rx_full && !rx_pop);
    ferr_d   = (ferr_q   & ~sts_clr[1]) | ferr_set;
    tx_ovf_d = (tx_ovf_q & ~sts_clr[2]) | (tx_push && tx_full && !tx_pop);
    irq_d    = (ctrl_q[0] & status.rx_avail) |
               (ctrl_q[1] & status.tx_empty & ~status.tx_busy);
  end

  // TX: bytes leave IDLE on a tick; STOP chains straight into the next START
  always_comb begin
    tx_state_d = tx_state_q;
    tx_tcnt_d  = tx_tcnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_pop     = 1'b0;
    if (tick) begin
      tx_tcnt_d = tx_tcnt_q + TCNT_W'(1);
      case (tx_state_q)
        IDLE: begin
          tx_tcnt_d = '0;
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_sh_d    = tx_head;
            tx_state_d = START;
          end
        end
        START: if (tx_tcnt_q == TCNT_LAST) begin
          tx_bit_d   = '0;
          tx_state_d = DATA;
        end
        DATA: if (tx_tcnt_q == TCNT_LAST) begin
          if (tx_bit_q == 3'd7) tx_state_d = STOP;
          else begin
            tx_bit_d = tx_bit_q + 3'd1;
            tx_sh_d  = {1'b0, tx_sh_q[7:1]};
          end
        end
        default: if (tx_tcnt_q == TCNT_LAST) begin
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_sh_d    = tx_head;
            tx_state_d = START;
          end else tx_state_d = IDLE;
        end
      endcase
    end
    case (tx_state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = tx_sh_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // RX: start confirmed mid-bit, then every 16 ticks lands on a bit centre
  always_comb begin
    rx_state_d = rx_state_q;
    rx_tcnt_d  = rx_tcnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_wait_d  = rx_wait_q;
    rx_push    = 1'b0;
    ferr_set   = 1'b0;
    case (rx_state_q)
      IDLE: if (!rx_s2_q) begin
        rx_tcnt_d  = '0;
        rx_state_d = START;
      end
      START: if (tick) begin
        rx_tcnt_d = rx_tcnt_q + TCNT_W'(1);
        if (rx_tcnt_q == TCNT_MID) begin
          rx_tcnt_d  = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s2_q ? IDLE : DATA;
        end
      end
      DATA: if (tick) begin
        rx_tcnt_d = rx_tcnt_q + TCNT_W'(1);
        if (rx_tcnt_q == TCNT_LAST) begin
          rx_sh_d = {rx_s2_q, rx_sh_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = STOP;
          else rx_bit_d = rx_bit_q + 3'd1;
        end
      end
      default: begin
        if (rx_wait_q) begin
          if (rx_s2_q) begin
            rx_wait_d  = 1'b0;
            rx_state_d = IDLE;
          end
        end else if (tick) begin
          rx_tcnt_d = rx_tcnt_q + TCNT_W'(1);
          if (rx_tcnt_q == TCNT_LAST) begin
            if (rx_s2_q) begin
              rx_push    = 1'b1;
              rx_state_d = IDLE;
            end else begin
              ferr_set  = 1'b1;
              rx_wait_d = 1'b1;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q      <= DIV_W'(DEFAULT_DIV);
      tick_cnt_q <= '0;
      ctrl_q     <= '0;
      rdata_q    <= '0;
      rx_ovr_q   <= 1'b0;
      ferr_q     <= 1'b0;
      tx_ovf_q   <= 1'b0;
      irq_q      <= 1'b0;
      tx_state_q <= IDLE;
      tx_tcnt_q  <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_q       <= 1'b1;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_state_q <= IDLE;
      rx_tcnt_q  <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_wait_q  <= 1'b0;
    end else begin
      div_q      <= div_d;
      tick_cnt_q <= tick_cnt_d;
      ctrl_q     <= ctrl_d;
      rdata_q    <= rdata_d;
      rx_ovr_q   <= rx_ovr_d;
      ferr_q     <= ferr_d;
      tx_ovf_q   <= tx_ovf_d;
      irq_q      <= irq_d;
      tx_state_q <= tx_state_d;
      tx_tcnt_q  <= tx_tcnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_q       <= tx_d;
      rx_s1_q    <= rx_i;
      rx_s2_q    <= rx_s1_q;
      rx_state_q <= rx_state_d;
      rx_tcnt_q  <= rx_tcnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_wait_q  <= rx_wait_d;
    end
  end

  assign rdata_o = rdata_q;
  assign tx_o    = tx_q;
  assign irq_o   = irq_q;

endmodule

// File: tb/tb_uart_mmio.sv
// Directed bench for uart_mmio: register reset values, TX waveform timing,
// loopback, RX overrun, framing/glitch handling, interrupt and mid-frame reset.
module tb_uart_mmio;

  localparam int BIT_CLKS = 64;  // DIV=3 -> 4 clocks per tick, 16 ticks per bit

  logic clk = 1'b0, rst_n = 1'b0, sel = 1'b0, we = 1'b0, re = 1'b0;
  logic rx_drv = 1'b1, loop_en = 1'b0;
  logic [1:0] addr = 2'd0;
  logic [15:0] wdata = 16'h0000;
  logic [15:0] rdata;
  logic tx, irq, rx_line;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;
  assign rx_line = loop_en ? tx : rx_drv;

  uart_mmio dut (
    .clk_i(clk), .rst_ni(rst_n), .sel_i(sel), .addr_i(addr), .we_i(we), .re_i(re),
    .wdata_i(wdata), .rdata_o(rdata), .rx_i(rx_line), .tx_o(tx), .irq_o(irq)
  );

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    cyc(1);
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [15:0] d);
    sel = 1'b1; re = 1'b1; addr = a;
    cyc(1);
    sel = 1'b0; re = 1'b0;
    d = rdata;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx_drv = 1'b0;
    cyc(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      cyc(BIT_CLKS);
    end
    rx_drv = stop_bit;
    cyc(BIT_CLKS);
    rx_drv = 1'b1;
    cyc(BIT_CLKS);
  endtask

  // Poll STATUS until the transmitter is empty and idle
  task automatic wait_tx_done(input int limit, output bit ok);
    logic [15:0] v;
    ok = 1'b0;
    for (int n = 0; n < limit && !ok; n++) begin
      bus_read(2'd1, v);
      if (v[4:3] == 2'b01) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [15:0] v;
    rst_n = 1'b0;
    cyc(3);
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx: got %b expected 1", tx); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq: got %b expected 0", irq); end
    checks++; if (rdata !== 16'h0000) begin failures++; $display("FAIL reset_rdata: got %h expected 0000", rdata); end
    rst_n = 1'b1;
    cyc(2);
    bus_read(2'd1, v);
    checks++; if (v !== 16'h0008) begin failures++; $display("FAIL reset_status: got %h expected 0008", v); end
    bus_read(2'd2, v);
    checks++; if (v !== 16'd26) begin failures++; $display("FAIL reset_div: got %0d expected 26", v); end
    bus_read(2'd3, v);
    checks++; if (v !== 16'h0000) begin failures++; $display("FAIL reset_ctrl: got %h expected 0000", v); end
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx_idle: got %b expected 1", tx); end
  endtask

  task automatic test_tx_frame();
    logic [15:0] v, mid;
    logic [9:0] fr;
    logic cap [660];
    int w, bad_at;
    fr = {1'b1, 8'hA5, 1'b0};
    mid = 16'hxxxx;
    bus_write(2'd2, 16'd3);
    bus_write(2'd0, 16'h00A5);
    w = 0;
    while (tx !== 1'b0 && w < 200) begin cyc(1); w++; end
    checks++; if (tx !== 1'b0) begin failures++; $display("FAIL tx_start_seen: got %b expected 0", tx); end
    for (int c = 0; c < 660; c++) begin
      cap[c] = tx;
      if (c == 300) bus_read(2'd1, mid);
      else cyc(1);
    end
    bad_at = -1;
    for (int c = 659; c >= 0; c--) begin
      if (cap[c] !== ((c < 640) ? fr[c / BIT_CLKS] : 1'b1)) bad_at = c;
    end
    checks++; if (bad_at != -1) begin failures++; $display("FAIL tx_waveform: got %b at clock %0d expected %b", cap[bad_at], bad_at, (bad_at < 640) ? fr[bad_at / BIT_CLKS] : 1'b1); end
    checks++; if (mid !== 16'h0018) begin failures++; $display("FAIL tx_busy_midframe: got %h expected 0018", mid); end
    bus_read(2'd1, v);
    checks++; if (v !== 16'h0008) begin failures++; $display("FAIL tx_after_frame_status: got %h expected 0008", v); end
  endtask

  task automatic test_loopback();
    logic [15:0] v;
    logic [15:0] exp_b [3];
    bit ok;
    exp_b[0] = 16'h003C; exp_b[1] = 16'h0000; exp_b[2] = 16'h00FF;
    loop_en = 1'b1;
    for (int i = 0; i < 3; i++) bus_write(2'd0, exp_b[i]);
    wait_tx_done(3000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL loop_tx_timeout: got busy expected idle"); end
    cyc(10);
    bus_read(2'd1, v);
    checks++; if (v !== 16'h0009) begin failures++; $display("FAIL loop_status: got %h expected 0009", v); end
    for (int i = 0; i < 3; i++) begin
      bus_read(2'd0, v);
      checks++; if (v !== exp_b[i]) begin failures++; $display("FAIL loop_data%0d: got %h expected %h", i, v, exp_b[i]); end
    end
    bus_read(2'd0, v);
    checks++; if (v !== 16'h0000) begin failures++; $display("FAIL loop_empty_read: got %h expected 0000", v); end
    loop_en = 1'b0;
  endtask

  task automatic test_overrun();
    logic [15:0] v;
    bit ok;
    loop_en = 1'b1;
    bus_write(2'd0, 16'h0010);
    cyc(10);
    for (int i = 1; i < 9; i++) bus_write(2'd0, 16'h0010 + 16'(i));
    wait_tx_done(8000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL ovr_tx_timeout: got busy expected idle"); end
    cyc(10);
    bus_read(2'd1, v);
    checks++; if (v !== 16'h002B) begin failures++; $display("FAIL ovr_status: got %h expected 002B", v); end
    bus_write(2'd1, 16'h0020);
    bus_read(2'd1, v);
    checks++; if (v !== 16'h000B) begin failures++; $display("FAIL ovr_clear: got %h expected 000B", v); end
    for (int i = 0; i < 8; i++) begin
      bus_read(2'd0, v);
      checks++; if (v !== 16'h0010 + 16'(i)) begin failures++; $display("FAIL ovr_data%0d: got %h expected %h", i, v, 16'h0010 + 16'(i)); end
    end
    bus_read(2'd1, v);
    checks++; if (v !== 16'h0008) begin failures++; $display("FAIL ovr_drained: got %h expected 0008", v); end
    loop_en = 1'b0;
  endtask

  task automatic test_frame_err();
    logic [15:0] v;
    send_frame(8'h55, 1'b0);
    bus_read(2'd1, v);
    checks++; if (v !== 16'h0048) begin failures++; $display("FAIL ferr_status: got %h expected 0048", v); end
    bus_read(2'd0, v);
    checks++; if (v !== 16'h0000) begin failures++; $display("FAIL ferr_no_push: got %h expected 0000", v); end
    bus_write(2'd1, 16'h0040);
    bus_read(2'd1, v);
    checks++; if (v !== 16'h0008) begin failures++; $display("FAIL ferr_clear: got %h expected 0008", v); end
    rx_drv = 1'b0;
    cyc(8);
    rx_drv = 1'b1;
    cyc(200);
    bus_read(2'd1, v);
    checks++; if (v !== 16'h0008) begin failures++; $display("FAIL glitch_status: got %h expected 0008", v); end
    send_frame(8'hC3, 1'b1);
    bus_read(2'd0, v);
    checks++; if (v !== 16'h00C3) begin failures++; $display("FAIL ext_frame_data: got %h expected 00C3", v); end
  endtask

  task automatic test_irq();
    logic [15:0] v;
    logic prev_irq;
    bit seen;
    bus_write(2'd3, 16'h0001);
    cyc(2);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_idle: got %b expected 0", irq); end
    seen = 1'b0;
    prev_irq = irq;
    fork
      send_frame(8'h12, 1'b1);
      begin
        for (int n = 0; n < 1200 && !seen; n++) begin
          bus_read(2'd1, v);
          if (v[0] === 1'b1) begin
            seen = 1'b1;
            checks++; if (irq !== 1'b1 || prev_irq !== 1'b0) begin failures++; $display("FAIL irq_timing: got %b then %b expected 0 then 1", prev_irq, irq); end
          end
          prev_irq = irq;
        end
      end
    join
    checks++; if (!seen) begin failures++; $display("FAIL irq_rx_timeout: got no rx_avail expected rx_avail"); end
    bus_read(2'd0, v);
    checks++; if (v !== 16'h0012) begin failures++; $display("FAIL irq_data: got %h expected 0012", v); end
    cyc(1);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_clear: got %b expected 0", irq); end
    bus_write(2'd3, 16'h0002);
    cyc(1);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_tx_empty: got %b expected 1", irq); end
    bus_write(2'd3, 16'h0000);
  endtask

  task automatic test_reset_mid_tx();
    logic [15:0] v;
    int w;
    bus_write(2'd0, 16'h0000);
    w = 0;
    while (tx !== 1'b0 && w < 200) begin cyc(1); w++; end
    checks++; if (tx !== 1'b0) begin failures++; $display("FAIL rst_tx_start: got %b expected 0", tx); end
    cyc(100);
    #3 rst_n = 1'b0;
    #1;
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL rst_async_tx: got %b expected 1", tx); end
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    bus_read(2'd1, v);
    checks++; if (v !== 16'h0008) begin failures++; $display("FAIL rst_status: got %h expected 0008", v); end
    bus_read(2'd2, v);
    checks++; if (v !== 16'd26) begin failures++; $display("FAIL rst_div: got %0d expected 26", v); end
    w = 0;
    for (int n = 0; n < 800; n++) begin
      if (tx !== 1'b1) w++;
      cyc(1);
    end
    checks++; if (w != 0) begin failures++; $display("FAIL rst_tx_quiet: got %0d low clocks expected 0", w); end
  endtask

  initial begin
    test_reset();
    test_tx_frame();
    test_loopback();
    test_overrun();
    test_frame_err();
    test_irq();
    test_reset_mid_tx();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_mmio.md
Name: uart_mmio

Overview:
Memory-mapped full-duplex UART peripheral for the CPU data bus. Replaces the separate baud generator and receive-only UART with one block that has a runtime-programmable divisor, parametrised TX and RX FIFOs, sticky error flags and an interrupt line. Sits beside memory on the CPU bus, selected by the memory address decoder, and drives the board rx/tx pins.

Parameters:
WORD_SIZE, 16, CPU bus data width (≥ 8)
TX_DEPTH, 8, TX FIFO entries (power of 2, ≥ 2)
RX_DEPTH, 8, RX FIFO entries (power of 2, ≥ 2)
DIV_W, 16, divisor register width
DEFAULT_DIV, 26, reset divisor: clocks per 1/16-bit tick minus 1 (50 MHz, 115200 baud)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
sel  in  1  chip select from address decoder
addr  in  2  register offset
we  in  1  write strobe; qualified by sel
re  in  1  read strobe; qualified by sel
wdata  in  WORD_SIZE  write data
rdata  out  WORD_SIZE  registered read data
rx  in  1  serial input, asynchronous to clk
tx  out  1  serial output, idle high
irq  out  1  registered interrupt request

Behaviour:
- Reset values: rdata=0, tx=1, irq=0, FIFOs empty, flags 0, CTRL=0, divisor=DEFAULT_DIV.
- Registers:
  - 0 DATA: write pushes wdata[7:0] to TX FIFO. Read returns {0, RX head} and pops.
  - 1 STATUS: bit0 rx_avail, bit1 rx_full, bit2 tx_full, bit3 tx_empty, bit4 tx_busy, bit5 rx_overrun, bit6 frame_err, bit7 tx_ovf; upper bits 0. Writing 1 to bits 5-7 clears them; other bits are read-only.
  - 2 DIV: divisor, DIV_W bits, zero-extended on read.
  - 3 CTRL: bit0 rx_irq_en, bit1 tx_irq_en.
- rdata is valid one cycle after re&sel and holds until the next read. A DATA read pops on that same edge.
- Pop on empty RX FIFO returns 0 and leaves pointers unchanged. Push to full TX FIFO drops the byte and sets tx_ovf.
- Simultaneous pop and push on a full RX FIFO: both succeed, no overrun. Simultaneous bus clear and hardware set of the same flag: set wins.
- Tick generator:
  - Counter runs 0..div and emits a 1-cycle tick at div, so a tick occurs every div+1 clocks; 16 ticks make one bit.
  - A DIV write reloads the counter to 0.
  - div=0 gives a tick every clock.
- TX FSM IDLE→START→DATA→STOP→IDLE:
  - Leaves IDLE when the FIFO is non-empty, on the next tick; pops the byte at that point.
  - Frame is start bit 0, 8 data bits LSB first, stop bit 1, each held 16 ticks.
  - Back-to-back bytes go out with no idle gap.
  - tx_busy=1 whenever the FSM is not in IDLE.
- RX path:
  - rx passes through a 2-flop synchroniser.
  - FSM IDLE→START→DATA→STOP→IDLE.
  - IDLE waits for a synced low, then resets the tick phase.
  - START samples at tick 8; if high, it was a glitch: return to IDLE with no flag.
  - DATA samples each bit at its 16-tick midpoint.
  - STOP sample high pushes the byte; if the FIFO is full, the byte is dropped and rx_overrun is set.
  - STOP sample low sets frame_err, pushes nothing, and returns to IDLE once rx is high.
- irq is registered: (rx_irq_en & rx_avail) | (tx_irq_en & tx_empty & ~tx_busy).
- Reset asserted mid-frame aborts both FSMs immediately: tx=1, FIFOs flushed.
- Writes are ignored when sel=0. Read and write in the same cycle are both performed.

Decomposition:
- Package uart_pkg holds register offsets, STATUS bit indices, the shared 4-state FSM enum (IDLE/START/DATA/STOP), and TICKS_PER_BIT=16.
- Sub-module sync_fifo(WIDTH, DEPTH) is instantiated twice. It provides push/pop/full/empty/head with 1-cycle write visibility, and uses extra-bit pointers for full/empty.

Test Plan:
- Reset, then read STATUS → 0x0008; DIV → 26; tx=1 throughout.
- DIV=3, write DATA 0xA5 → tx shows start, bits 1,0,1,0,0,1,0,1, stop, each 64 clocks; total frame 640 clocks; tx_busy=1 during the frame, then STATUS bit3 and bit4 show empty/idle.
- Loop tx→rx, DIV=3, write 0x3C, 0x00, 0xFF → rx_avail; three DATA reads return 0x003C, 0x0000, 0x00FF; a fourth read returns 0x0000.
- Drive RX_DEPTH+1 frames with no reads → rx_full=1 and rx_overrun=1; the FIFO holds the first 8 bytes. Write STATUS 0x20 → overrun clears, rx_full stays 1.
- Stop bit forced low on a frame of 0x55 → frame_err=1 and nothing pushed. A 2-tick low glitch on rx → no flag, no push.
- CTRL=1, receive 0x12 → irq=1 one cycle after the push; read DATA → irq=0 within 2 cycles. Assert reset mid-TX → tx=1 immediately and STATUS=0x0008 after release.
